// File: rtl/video_pkg.sv
// Shared video constants and pixel types for the sprite line buffer slice.
//   PIX_W     : pixel word width; bits [3:0] colour index, upper bits palette/priority
//   ADDR_W    : line address width; each line bank holds 2**ADDR_W pixels
//   TRANS_NIB : colour nibble that marks a pixel as transparent
//   TRANS_PIX : the "empty" pixel written back by the read-side clear
package video_pkg;

    localparam int          PIX_W     = 11;
    localparam int          ADDR_W    = 9;
    localparam logic [3:0]  TRANS_NIB = 4'hF;

    // Colour nibble in the low bits, palette/priority attributes above it.
    typedef struct packed {
        logic [PIX_W-5:0] attr;
        logic [3:0]       colour;
    } pixel_t;

    localparam pixel_t TRANS_PIX = '{attr: {(PIX_W-4){1'b1}}, colour: TRANS_NIB};

    // True when the pixel carries a visible colour.
    function automatic logic pix_is_opaque(input logic [PIX_W-1:0] p);
        return (p[3:0] != TRANS_NIB);
    endfunction

endpackage

// File: rtl/sprite_line_buffer_if.sv
// Renderer <-> line buffer interface.
//   wr_en / wr_x / wr_data : renderer pixel write strobe, x position and pixel
//   line_start             : one-clk pulse telling the renderer to start a line
//   render_vc              : line number the renderer must draw
// master = renderer, slave = line buffer.
interface sprite_line_buffer_if;
    import video_pkg::*;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_x;
    logic [PIX_W-1:0]  wr_data;
    logic              line_start;
    logic [8:0]        render_vc;

    modport master (
        output wr_en, wr_x, wr_data,
        input  line_start, render_vc
    );

    modport slave (
        input  wr_en, wr_x, wr_data,
        output line_start, render_vc
    );

endinterface

// File: rtl/lb_dpram.sv
// Single-clock simple dual-port RAM, one write port and one registered read port.
//   clk            : clock
//   we/waddr/wdata : write port
//   re/raddr       : read enable and address; rdata updates on the enabled edge
//   rdata          : registered read data, holds between reads
// Contents and read register are deliberately not reset.
module lb_dpram #(
    parameter int DW = 11,
    parameter int AW = 9
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem_q [2**AW];
    logic [DW-1:0] rdata_q;

    // Write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Registered read port; read-old-data if written on the same edge.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/sprite_line_buffer.sv
// Ping-pong sprite line buffer between the video timing generator and the
// sprite renderer. The renderer fills the back bank with line N+1 while the
// front bank is scanned out for line N; banks swap at the start of each
// horizontal blank and scanned pixels are cleared back to transparent.
//   clk, reset      : clock, synchronous active-high reset
//   clk_pix         : pixel clock enable (at most 1 in 2 clk cycles)
//   hc, vc, hbl, vbl: timing generator counters and blanks
//   rnd             : renderer interface (write port, line_start, render_vc)
//   pix_out         : scanned-out sprite pixel (1 clk_pix latency)
//   pix_opaque      : pix_out colour nibble is not transparent
//   flip            : only with LINEBUF_FLIP_EN defined; mirrors the scan address
module sprite_line_buffer
    import video_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clk_pix,
    input  logic [8:0]            hc,
    input  logic [8:0]            vc,
    input  logic                  hbl,
    input  logic                  vbl,
`ifdef LINEBUF_FLIP_EN
    input  logic                  flip,
`endif
    sprite_line_buffer_if.slave   rnd,
    output logic [PIX_W-1:0]      pix_out,
    output logic                  pix_opaque
);

    localparam logic [PIX_W-1:0] TRANS = TRANS_PIX;

    // Registered state
    logic              bank_sel_q,  bank_sel_d;
    logic              hbl_d_q,     hbl_d_d;
    logic              line_start_q, line_start_d;
    logic [8:0]        render_vc_q, render_vc_d;
    logic [1:0]        valid_cnt_q, valid_cnt_d;
    logic              show_q,      show_d;
    logic              rd_bank_q,   rd_bank_d;
    logic              clr_pend_q,  clr_pend_d;
    logic [ADDR_W-1:0] clr_addr_q,  clr_addr_d;

    // Combinational controls
    logic              swap_s;
    logic              rd_fire_s;
    logic              rnd_we_s;
    logic [ADDR_W-1:0] rd_addr_s;
    logic              we_s    [2];
    logic [ADDR_W-1:0] waddr_s [2];
    logic [PIX_W-1:0]  wdata_s [2];
    logic              re_s    [2];
    logic [PIX_W-1:0]  rdata_s [2];
    logic              unused_s;

    // vbl only matters through hc/hbl; swaps keep running through vblank.
    assign unused_s = vbl;

`ifdef LINEBUF_FLIP_EN
    // (2**ADDR_W-1) - x is the bitwise complement of x.
    assign rd_addr_s = flip ? ~hc[ADDR_W-1:0] : hc[ADDR_W-1:0];
`else
    assign rd_addr_s = hc[ADDR_W-1:0];
`endif

    // Event decode and per-bank port muxing. Renderer targets bank_sel, scan and
    // clear target the other bank; both use bank_sel before this edge's update.
    always_comb begin
        logic hit;
        swap_s    = clk_pix && hbl && !hbl_d_q;
        rd_fire_s = clk_pix && !hbl;
        rnd_we_s  = rnd.wr_en && pix_is_opaque(rnd.wr_data);
        for (int b = 0; b < 2; b++) begin
            hit        = rnd_we_s && (bank_sel_q == 1'(b));
            we_s[b]    = hit || (clr_pend_q && (rd_bank_q == 1'(b)));
            waddr_s[b] = hit ? rnd.wr_x    : clr_addr_q;
            wdata_s[b] = hit ? rnd.wr_data : TRANS;
            re_s[b]    = rd_fire_s && (bank_sel_q != 1'(b));
        end
    end

    // Next-state logic for swap, masking and the read/clear pipeline.
    always_comb begin
        hbl_d_d      = hbl_d_q;
        bank_sel_d   = bank_sel_q;
        line_start_d = 1'b0;
        render_vc_d  = render_vc_q;
        valid_cnt_d  = valid_cnt_q;
        show_d       = show_q;
        rd_bank_d    = rd_bank_q;
        clr_pend_d   = rd_fire_s;
        clr_addr_d   = clr_addr_q;

        if (clk_pix) begin
            hbl_d_d = hbl;
            // Only show real data once both banks have been scanned (and cleared).
            show_d  = !hbl && (valid_cnt_q == 2'd2);
        end else begin
            hbl_d_d = hbl_d_q;
        end

        if (swap_s) begin
            bank_sel_d   = ~bank_sel_q;
            line_start_d = 1'b1;
            render_vc_d  = vc + 9'd1;
            if (valid_cnt_q != 2'd2) begin
                valid_cnt_d = valid_cnt_q + 2'd1;
            end else begin
                valid_cnt_d = valid_cnt_q;
            end
        end else begin
            bank_sel_d = bank_sel_q;
        end

        // The clear of this address goes out on the next clk, before the next clk_pix.
        if (rd_fire_s) begin
            rd_bank_d  = ~bank_sel_q;
            clr_addr_d = rd_addr_s;
        end else begin
            rd_bank_d  = rd_bank_q;
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            hbl_d_q      <= 1'b0;
            bank_sel_q   <= 1'b0;
            line_start_q <= 1'b0;
            render_vc_q  <= 9'd0;
            valid_cnt_q  <= 2'd0;
            show_q       <= 1'b0;
            rd_bank_q    <= 1'b0;
            clr_pend_q   <= 1'b0;
            clr_addr_q   <= '0;
        end else begin
            hbl_d_q      <= hbl_d_d;
            bank_sel_q   <= bank_sel_d;
            line_start_q <= line_start_d;
            render_vc_q  <= render_vc_d;
            valid_cnt_q  <= valid_cnt_d;
            show_q       <= show_d;
            rd_bank_q    <= rd_bank_d;
            clr_pend_q   <= clr_pend_d;
            clr_addr_q   <= clr_addr_d;
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_bank
        lb_dpram #(.DW(PIX_W), .AW(ADDR_W)) u_ram (
            .clk   (clk),
            .we    (we_s[g]),
            .waddr (waddr_s[g]),
            .wdata (wdata_s[g]),
            .re    (re_s[g]),
            .raddr (rd_addr_s),
            .rdata (rdata_s[g])
        );
    end

    // The RAM read register is the pixel output register; show_q/rd_bank_q are
    // captured on the same clk_pix edge, so pix_out only changes on that edge.
    assign pix_out        = show_q ? rdata_s[rd_bank_q] : TRANS;
    assign pix_opaque     = pix_is_opaque(pix_out);
    assign rnd.line_start = line_start_q;
    assign rnd.render_vc  = render_vc_q;

endmodule

// File: tb/tb_sprite_line_buffer.sv
// Self-checking bench for sprite_line_buffer: table of lines (pre-line writes,
// expected opaque pixel, expected render_vc) plus a mid-line reset sequence.
module tb_sprite_line_buffer;

    localparam int          HACT = 112;
    localparam int          HTOT = 128;
    localparam logic [10:0] TP   = 11'h7FF;

    logic        clk = 1'b0;
    logic        reset, clk_pix, hbl, vbl;
    logic [8:0]  hc, vc;
    logic [10:0] pix_out;
    logic        pix_opaque;
`ifdef LINEBUF_FLIP_EN
    logic        flip;
`endif

    int errors = 0;
    int checks = 0;
    int ls_cnt = 0;

    typedef struct {
        logic [8:0]  vc;
        int          wx1;
        logic [10:0] wd1;
        int          wx2;
        logic [10:0] wd2;
        int          ex;
        logic [10:0] ep;
        logic [8:0]  rvc;
    } line_vec_t;

    line_vec_t vecs [12];

    sprite_line_buffer_if rif();

    sprite_line_buffer dut (
        .clk        (clk),
        .reset      (reset),
        .clk_pix    (clk_pix),
        .hc         (hc),
        .vc         (vc),
        .hbl        (hbl),
        .vbl        (vbl),
`ifdef LINEBUF_FLIP_EN
        .flip       (flip),
`endif
        .rnd        (rif),
        .pix_out    (pix_out),
        .pix_opaque (pix_opaque)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        if (rif.line_start) ls_cnt++;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " pix_out"},    {21'd0, pix_out},      {21'd0, TP});
        chk({tag, " pix_opaque"}, {31'd0, pix_opaque},   32'd0);
        chk({tag, " line_start"}, {31'd0, rif.line_start}, 32'd0);
        chk({tag, " render_vc"},  {23'd0, rif.render_vc}, 32'd0);
    endtask

    task automatic wr(input int x, input logic [10:0] d);
        rif.wr_en   = 1'b1;
        rif.wr_x    = 9'(x);
        rif.wr_data = d;
        tick();
        rif.wr_en   = 1'b0;
    endtask

    // One scan line: pixel for hc=h is checked right after its clk_pix edge.
    task automatic run_line(input logic [8:0] v, input int ex, input logic [10:0] ep,
                            input int last_h);
        logic [10:0] e;
        ls_cnt = 0;
        vc     = v;
        for (int h = 0; h <= last_h; h++) begin
            hc      = 9'(h);
            hbl     = (h >= HACT);
            clk_pix = 1'b1;
            tick();
            if (h < HACT) begin
                e = (h == ex) ? ep : TP;
                chk($sformatf("pix vc%0d x%0d", v, h), {20'd0, pix_opaque, pix_out},
                    {20'd0, (e[3:0] != 4'hF), e});
            end
            clk_pix = 1'b0;
            tick();
        end
    endtask

    initial begin
        reset = 1'b1; clk_pix = 1'b0; hc = 9'd0; vc = 9'd0; hbl = 1'b0; vbl = 1'b0;
        rif.wr_en = 1'b0; rif.wr_x = 9'd0; rif.wr_data = 11'd0;
`ifdef LINEBUF_FLIP_EN
        flip = 1'b0;
`endif
        //          vc      wx1  wd1      wx2  wd2      ex   ep       rvc
        vecs[0]  = '{9'd8,   -1, 11'h000, -1, 11'h000, -1, 11'h000, 9'd9};
        vecs[1]  = '{9'd9,   -1, 11'h000, -1, 11'h000, -1, 11'h000, 9'd10};
        vecs[2]  = '{9'd10,  40, 11'h123, -1, 11'h000, -1, 11'h000, 9'd11};
        vecs[3]  = '{9'd11,  -1, 11'h000, -1, 11'h000, 40, 11'h123, 9'd12};
        vecs[4]  = '{9'd12,  -1, 11'h000, -1, 11'h000, -1, 11'h000, 9'd13};
        vecs[5]  = '{9'd13,  -1, 11'h000, -1, 11'h000, -1, 11'h000, 9'd14};
        vecs[6]  = '{9'd14,   5, 11'h2A1,  5, 11'h05F, -1, 11'h000, 9'd15};
        vecs[7]  = '{9'd15,  -1, 11'h000, -1, 11'h000,  5, 11'h2A1, 9'd16};
        vecs[8]  = '{9'd255, -1, 11'h000, -1, 11'h000, -1, 11'h000, 9'd256};
        vecs[9]  = '{9'd511, -1, 11'h000, -1, 11'h000, -1, 11'h000, 9'd0};
        vecs[10] = '{9'd20,   0, 11'h6A0, -1, 11'h000, -1, 11'h000, 9'd21};
        vecs[11] = '{9'd21,  -1, 11'h000, -1, 11'h000,  0, 11'h6A0, 9'd22};

        repeat (3) tick();
        chk_reset("por");
        reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            if (vecs[i].wx1 >= 0) wr(vecs[i].wx1, vecs[i].wd1);
            if (vecs[i].wx2 >= 0) wr(vecs[i].wx2, vecs[i].wd2);
            run_line(vecs[i].vc, vecs[i].ex, vecs[i].ep, HTOT - 1);
            chk($sformatf("line_start count vc%0d", vecs[i].vc), ls_cnt, 32'd1);
            chk($sformatf("render_vc vc%0d", vecs[i].vc), {23'd0, rif.render_vc},
                {23'd0, vecs[i].rvc});
        end

        // Mid-line reset with data left behind in both banks.
        wr(60, 11'h3C4);
        wr(105, 11'h2D5);
        run_line(9'd30, -1, TP, HTOT - 1);
        chk("line_start count vc30", ls_cnt, 32'd1);
        wr(70, 11'h1E6);
        run_line(9'd31, 60, 11'h3C4, 100);
        reset = 1'b1;
        tick();
        chk_reset("mid");
        tick();
        reset = 1'b0;

        // Two masked lines, then a visible line whose bank was cleared while masked.
        for (int v = 40; v < 43; v++) begin
            run_line(9'(v), -1, TP, HTOT - 1);
            chk($sformatf("line_start count vc%0d", v), ls_cnt, 32'd1);
            chk($sformatf("render_vc vc%0d", v), {23'd0, rif.render_vc}, 32'(v + 1));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
